ram_dma: RTL and testbench
==========================

RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 Parameter AW, default 14, address width, matching the Ram16K address bus.
REQ-002 Parameter DW, default 16, data word width.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_mode  in  1  0 = copy, 1 = fill.
REQ-008 cmd_src  in  AW  copy source start address; ignored in fill mode.
REQ-009 cmd_dst  in  AW  destination start address.
REQ-010 cmd_len  in  AW  word count; 0 = no-op.
REQ-011 cmd_fill  in  DW  fill pattern; ignored in copy mode.
REQ-012 mem_addr  out  AW  drives the RAM addr port.
REQ-013 mem_wdata  out  DW  drives the RAM in port.
REQ-014 mem_ld  out  1  drives the RAM ld port (write enable).
REQ-015 mem_rdata  in  DW  RAM out port; combinational read of m[mem_addr].
REQ-016 busy  out  1  high from command acceptance until DONE inclusive.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 count  out  AW  words written by the current or last command.

Function
REQ-019 States SHALL be IDLE, RD, WR, FILL and DONE.
REQ-020 cmd_ready SHALL equal (state == IDLE); a command is accepted on the edge where cmd_valid && cmd_ready.
REQ-021 On acceptance, the block latches src_ptr, dst_ptr, remaining = cmd_len, the mode and the fill pattern, and clears count to 0.
REQ-022 On acceptance, the next state is DONE if cmd_len == 0, else FILL if cmd_mode = 1, else RD.
REQ-023 cmd_valid is ignored outside IDLE; latched command fields are unaffected by input changes after acceptance.
REQ-024 RD behaviour:
- mem_addr = src_ptr, mem_ld = 0.
- On the edge, data_q <= mem_rdata and src_ptr increments.
- Next state is WR.
REQ-025 WR behaviour:
- mem_addr = dst_ptr, mem_wdata = data_q, mem_ld = 1.
- On the edge, dst_ptr and count increment and remaining decrements.
- Next state is DONE if remaining == 1, else RD.
REQ-026 FILL behaviour:
- mem_addr = dst_ptr, mem_wdata = fill, mem_ld = 1.
- On the edge, dst_ptr and count increment and remaining decrements.
- Remains in FILL until remaining == 1, then goes to DONE.
REQ-027 DONE behaviour: done = 1 and mem_ld = 0 for exactly one cycle, then IDLE.
REQ-028 Latency from the acceptance edge to the done-high cycle:
- Copy: 2N+1 cycles.
- Fill: N+1 cycles.
- len = 0: 1 cycle.
REQ-029 Pointers SHALL wrap modulo 2^AW (address 2^AW-1 is followed by 0); cmd_len is at most 2^AW-1.
REQ-030 Copy is strictly forward, word by word: each word is read after all earlier writes.
REQ-031 Consequence of REQ-030: overlapping copies with dst in (src, src+len) replicate the source prefix; this behaviour is defined and not an error.
REQ-032 mem_ld SHALL be asserted only in WR and FILL, and exactly once per word.
REQ-033 In IDLE, DONE and RD, mem_wdata = 0; in IDLE and DONE, mem_addr = 0.
REQ-034 count holds its final value until the next acceptance.

Reset
REQ-035 While rst is high, outputs SHALL immediately (asynchronously) take these values:
- state = IDLE.
- mem_ld = 0, done = 0, busy = 0, cmd_ready = 1.
- count = 0, mem_addr = 0, mem_wdata = 0.
- data_q and all pointers = 0.
REQ-036 Reset mid-command aborts it with no further writes and no done pulse; words already written remain in the RAM.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Copy, src=0x0010, dst=0x0100, len=4, RAM[0x10..0x13]=A,B,C,D -> RAM[0x100..0x103]=A,B,C,D; done in cycle 9 after acceptance; count=4; exactly 4 mem_ld cycles.
- Fill, dst=0x3FFE, len=3, fill=0xBEEF -> writes 0x3FFE, 0x3FFF, 0x0000; done in cycle 4; count=3.
- len=0 -> done in cycle 1; no mem_ld; count=0.
- Overlap copy, src=0x20, dst=0x21, len=3, RAM[0x20]=X -> RAM[0x21..0x23]=X,X,X.
- rst asserted in the WR cycle of word 2 of a len=4 copy -> mem_ld drops in the same cycle; only word 1 written; no done pulse; cmd_ready=1.
- cmd_valid held high while busy, followed by a second command -> second command accepted only on the cycle after done; first command's results intact.

Source files
------------

// File: rtl/ram_dma.sv
// ram_dma: single-channel DMA engine for a Ram16K-style RAM with a
// combinational read port. Copies a block word by word (read then write)
// or fills a block with a constant pattern, then pulses done.
//
// Command handshake: a command is taken on any rising clk edge where
// cmd_valid && cmd_ready; cmd_ready is high only in IDLE, so cmd_valid is
// simply ignored while a command is in flight. All command fields are
// captured on that edge and later input changes have no effect.
`timescale 1ns/1ps
module ram_dma #(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_mode,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_fill,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_ld,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count,
  output logic [2:0]    state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] FILL = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] src_q,   src_d;
  logic [AW-1:0] dst_q,   dst_d;
  logic [AW-1:0] rem_q,   rem_d;
  logic [AW-1:0] count_q, count_d;
  logic [DW-1:0] fill_q,  fill_d;
  logic [DW-1:0] data_q,  data_d;

  // Next-state logic. The copy/fill mode is not kept as a separate flag:
  // it is fully encoded by which state the FSM enters on acceptance.
  // Pointers wrap naturally through AW-bit arithmetic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    count_d = count_q;
    fill_d  = fill_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          rem_d   = cmd_len;
          fill_d  = cmd_fill;
          count_d = '0;
          if (cmd_len == '0)   state_d = DONE;
          else if (cmd_mode)   state_d = FILL;
          else                 state_d = RD;
        end
      end
      RD: begin
        data_d  = mem_rdata;
        src_d   = src_q + ONE;
        state_d = WR;
      end
      WR: begin
        dst_d   = dst_q + ONE;
        count_d = count_q + ONE;
        rem_d   = rem_q - ONE;
        state_d = (rem_q == ONE) ? DONE : RD;
      end
      FILL: begin
        dst_d   = dst_q + ONE;
        count_d = count_q + ONE;
        rem_d   = rem_q - ONE;
        state_d = (rem_q == ONE) ? DONE : FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      fill_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode the current state only, so an asynchronous reset
  // drops mem_ld in the same cycle it is asserted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_ld    = 1'b0;
    case (state_q)
      RD: begin
        mem_addr = src_q;
      end
      WR: begin
        mem_addr  = dst_q;
        mem_wdata = data_q;
        mem_ld    = 1'b1;
      end
      FILL: begin
        mem_addr  = dst_q;
        mem_wdata = fill_q;
        mem_ld    = 1'b1;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ld    = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma: table of whole commands plus hand-written
// sequences for reset-abort and back-to-back command handling.
`timescale 1ns/1ps
module tb_ram_dma;

  localparam int AW = 14;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_mode;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] cmd_fill;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ld;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic [AW-1:0] count;
  logic [2:0]    state;

  ram_dma #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .cmd_fill  (cmd_fill),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ld    (mem_ld),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .state     (state)
  );

  // ---------------- RAM model (combinational read, clocked write) ----------------
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_ld) ram[mem_addr] <= mem_wdata;
  end

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one command, then samples every cycle on the falling edge until
  // done is seen (bounded). Cycle 1 is the first cycle after acceptance.
  task automatic run_cmd(input logic mode, input logic [AW-1:0] src,
                         input logic [AW-1:0] dst, input logic [AW-1:0] len,
                         input logic [DW-1:0] fill,
                         output int lat, output int lds,
                         output logic [AW-1:0] addr1, output logic ld1);
    @(negedge clk);
    check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_fill  = fill;
    @(posedge clk);
    @(negedge clk);
    addr1 = mem_addr;
    ld1   = mem_ld;
    // scramble inputs after acceptance: latched fields must not follow
    cmd_valid = 1'b0;
    cmd_mode  = ~mode;
    cmd_src   = 14'h1555;
    cmd_dst   = 14'h2AAA;
    cmd_len   = 14'h0007;
    cmd_fill  = 16'hDEAD;
    lat = 1;
    lds = 0;
    while (!done && lat < 100) begin
      if (mem_ld) lds++;
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [DW-1:0] fill;
    int            exp_lat;
    int            exp_lds;
    logic [AW-1:0] exp_count;
    logic [AW-1:0] exp_addr1;
    logic          exp_ld1;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat, lds;
    logic [AW-1:0] addr1;
    logic ld1;
    logic [AW-1:0] cnt_at_done;

    vecs[0] = '{"copy4",   1'b0, 14'h0010, 14'h0100, 14'd4, 16'h0000, 9, 4, 14'd4, 14'h0010, 1'b0};
    vecs[1] = '{"fillwrap",1'b1, 14'h0000, 14'h3FFE, 14'd3, 16'hBEEF, 4, 3, 14'd3, 14'h3FFE, 1'b1};
    vecs[2] = '{"len0",    1'b0, 14'h0030, 14'h0300, 14'd0, 16'h0000, 1, 0, 14'd0, 14'h0000, 1'b0};
    vecs[3] = '{"overlap", 1'b0, 14'h0020, 14'h0021, 14'd3, 16'h0000, 7, 3, 14'd3, 14'h0020, 1'b0};
    vecs[4] = '{"fill1",   1'b1, 14'h0000, 14'h0200, 14'd1, 16'h1234, 2, 1, 14'd1, 14'h0200, 1'b1};

    for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
    ram[14'h0010] = 16'hAAAA;
    ram[14'h0011] = 16'hBBBB;
    ram[14'h0012] = 16'hCCCC;
    ram[14'h0013] = 16'hDDDD;
    ram[14'h0001] = 16'h7777;
    ram[14'h0300] = 16'h3030;
    ram[14'h0020] = 16'h5A5A;
    ram[14'h0021] = 16'h1111;
    ram[14'h0022] = 16'h2222;
    ram[14'h0023] = 16'h3333;
    ram[14'h0024] = 16'h4444;
    ram[14'h0040] = 16'h0001;
    ram[14'h0041] = 16'h0002;
    ram[14'h0042] = 16'h0003;
    ram[14'h0043] = 16'h0004;
    for (int i = 0; i < 4; i++) ram[14'h0140 + i] = 16'hFFFF;

    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_fill  = '0;

    // ---- reset state ----
    rst = 1'b1;
    #1;
    check("rst_state",     {29'd0, state},     32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_mem_ld",    {31'd0, mem_ld},    32'd0);
    check("rst_count",     {18'd0, count},     32'd0);
    check("rst_mem_addr",  {18'd0, mem_addr},  32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // ---- table-driven commands ----
    for (int v = 0; v < 5; v++) begin
      run_cmd(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill,
              lat, lds, addr1, ld1);
      check({vecs[v].name, "_latency"}, lat, vecs[v].exp_lat);
      check({vecs[v].name, "_ld_cycles"}, lds, vecs[v].exp_lds);
      check({vecs[v].name, "_addr1"}, {18'd0, addr1}, {18'd0, vecs[v].exp_addr1});
      check({vecs[v].name, "_ld1"}, {31'd0, ld1}, {31'd0, vecs[v].exp_ld1});
      check({vecs[v].name, "_ld_in_done"}, {31'd0, mem_ld}, 32'd0);
      check({vecs[v].name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      cnt_at_done = count;
      check({vecs[v].name, "_count"}, {18'd0, cnt_at_done}, {18'd0, vecs[v].exp_count});
      @(negedge clk);
      check({vecs[v].name, "_idle_after"}, {30'd0, done, busy}, 32'd0);
      repeat (2) @(negedge clk);
      check({vecs[v].name, "_count_hold"}, {18'd0, count}, {18'd0, vecs[v].exp_count});
    end

    // ---- memory contents left by the table ----
    check("copy_w0", {16'd0, ram[14'h0100]}, 32'hAAAA);
    check("copy_w1", {16'd0, ram[14'h0101]}, 32'hBBBB);
    check("copy_w2", {16'd0, ram[14'h0102]}, 32'hCCCC);
    check("copy_w3", {16'd0, ram[14'h0103]}, 32'hDDDD);
    check("copy_w4_untouched", {16'd0, ram[14'h0104]}, 32'h0000);
    check("fill_3ffe", {16'd0, ram[14'h3FFE]}, 32'hBEEF);
    check("fill_3fff", {16'd0, ram[14'h3FFF]}, 32'hBEEF);
    check("fill_wrap0", {16'd0, ram[14'h0000]}, 32'hBEEF);
    check("fill_wrap1_untouched", {16'd0, ram[14'h0001]}, 32'h7777);
    check("len0_untouched", {16'd0, ram[14'h0300]}, 32'h3030);
    check("overlap_21", {16'd0, ram[14'h0021]}, 32'h5A5A);
    check("overlap_22", {16'd0, ram[14'h0022]}, 32'h5A5A);
    check("overlap_23", {16'd0, ram[14'h0023]}, 32'h5A5A);
    check("overlap_24_untouched", {16'd0, ram[14'h0024]}, 32'h4444);
    check("fill1_200", {16'd0, ram[14'h0200]}, 32'h1234);
    check("fill1_201_untouched", {16'd0, ram[14'h0201]}, 32'h0000);

    // ---- reset during WR of word 2 of a len=4 copy ----
    begin
      int done_seen;
      done_seen = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_mode  = 1'b0;
      cmd_src   = 14'h0040;
      cmd_dst   = 14'h0140;
      cmd_len   = 14'd4;
      @(posedge clk);
      @(negedge clk);            // cycle 1: RD word 1
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk); // cycle 4: WR word 2
      check("abort_pre_ld",    {31'd0, mem_ld},    32'd1);
      check("abort_pre_addr",  {18'd0, mem_addr},  32'h0141);
      check("abort_pre_wdata", {16'd0, mem_wdata}, 32'h0002);
      rst = 1'b1;
      #1;
      check("abort_ld_drop",  {31'd0, mem_ld},    32'd0);
      check("abort_ready",    {31'd0, cmd_ready}, 32'd1);
      check("abort_busy",     {31'd0, busy},      32'd0);
      check("abort_count",    {18'd0, count},     32'd0);
      check("abort_state",    {29'd0, state},     32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (done || mem_ld) done_seen++;
      end
      check("abort_no_done_or_ld", done_seen, 0);
      check("abort_word1", {16'd0, ram[14'h0140]}, 32'h0001);
      check("abort_word2", {16'd0, ram[14'h0141]}, 32'hFFFF);
      check("abort_word3", {16'd0, ram[14'h0142]}, 32'hFFFF);
    end

    // ---- cmd_valid held while busy, then a second command ----
    begin
      int c;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_mode  = 1'b1;
      cmd_dst   = 14'h0400;
      cmd_len   = 14'd2;
      cmd_fill  = 16'h1111;
      @(posedge clk);            // command A accepted
      @(negedge clk);            // cycle 1: FILL
      cmd_dst  = 14'h0500;       // command B waits on the same valid
      cmd_fill = 16'h2222;
      check("b2b_a_addr", {18'd0, mem_addr}, 32'h0400);
      @(negedge clk);            // cycle 2: FILL
      @(negedge clk);            // cycle 3: DONE
      check("b2b_a_done",     {31'd0, done},      32'd1);
      check("b2b_ready_done", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);            // cycle 4: IDLE, B accepted at next edge
      check("b2b_idle_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);            // cycle 5: B FILL
      cmd_valid = 1'b0;
      check("b2b_b_busy", {31'd0, busy},     32'd1);
      check("b2b_b_addr", {18'd0, mem_addr}, 32'h0500);
      c = 0;
      while (!done && c < 50) begin
        @(negedge clk);
        c++;
      end
      check("b2b_b_latency", c + 1, 3);
      @(negedge clk);
      check("b2b_a_w0", {16'd0, ram[14'h0400]}, 32'h1111);
      check("b2b_a_w1", {16'd0, ram[14'h0401]}, 32'h1111);
      check("b2b_a_w2_untouched", {16'd0, ram[14'h0402]}, 32'h0000);
      check("b2b_b_w0", {16'd0, ram[14'h0500]}, 32'h2222);
      check("b2b_b_w1", {16'd0, ram[14'h0501]}, 32'h2222);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
